// File: rtl/piso_dir_serializer.sv
// piso_dir_serializer: parallel-in, serial-out shifter with per-word bit order.
// A word is accepted via load_valid/load_ready and emitted one bit per clock,
// qualified by bit_valid, with done marking the last bit of each frame.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no frame in progress; outputs quiet, ready for a new word
//   SHIFT | emitting shreg one bit per clock; cnt counts bits sent
//
module piso_dir_serializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             dir,
  output logic             serial_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] shreg;
  logic             dir_q;
  logic [CW-1:0]    cnt;
  logic             last_bit;
  logic             accept;

  // Last-bit and handshake decode; load_ready depends on registers only.
  always_comb begin
    last_bit   = (state_q == SHIFT) && (cnt == CNT_LAST);
    load_ready = (state_q == IDLE) || last_bit;
    accept     = load_valid && load_ready;
  end

  // State register; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: an accepted word always lands in SHIFT (also back-to-back).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = SHIFT;
      end
      SHIFT: begin
        if (last_bit && !accept) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture on accept, otherwise shift toward the emitting end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      dir_q <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      shreg <= load_data;
      dir_q <= dir;
      cnt   <= '0;
    end else if (state_q == SHIFT) begin
      if (dir_q) begin
        shreg <= {shreg[WIDTH-2:0], 1'b0};
      end else begin
        shreg <= {1'b0, shreg[WIDTH-1:1]};
      end
      cnt <= last_bit ? '0 : cnt + CW'(1);
    end
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    bit_valid  = (state_q == SHIFT);
    busy       = (state_q == SHIFT);
    done       = last_bit;
    serial_out = 1'b0;
    if (state_q == SHIFT) begin
      serial_out = dir_q ? shreg[WIDTH-1] : shreg[0];
    end
  end

endmodule

// File: tb/tb_piso_dir_serializer.sv
// Bench for piso_dir_serializer: directed vector table on a WIDTH=4 instance,
// hand sequences for reset behaviour, random loopback on WIDTH=4 and WIDTH=8.
module tb_piso_dir_serializer;

  logic       clk = 1'b0;
  logic       rst;

  logic       lv4, rdy4, dir4, so4, bv4, busy4, done4;
  logic [3:0] data4;
  logic       lv8, rdy8, dir8, so8, bv8, busy8, done8;
  logic [7:0] data8;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  piso_dir_serializer #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .load_valid(lv4), .load_ready(rdy4), .load_data(data4), .dir(dir4),
    .serial_out(so4), .bit_valid(bv4), .busy(busy4), .done(done4)
  );

  piso_dir_serializer #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .load_valid(lv8), .load_ready(rdy8), .load_data(data8), .dir(dir8),
    .serial_out(so8), .bit_valid(bv8), .busy(busy8), .done(done8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Check all four frame outputs plus load_ready of the WIDTH=4 instance.
  task automatic chk4(input string tag, input logic so, input logic bv,
                      input logic dn, input logic rdy, input logic bs);
    chk({tag, ".serial_out"}, {31'd0, so4},   {31'd0, so});
    chk({tag, ".bit_valid"},  {31'd0, bv4},   {31'd0, bv});
    chk({tag, ".done"},       {31'd0, done4}, {31'd0, dn});
    chk({tag, ".load_ready"}, {31'd0, rdy4},  {31'd0, rdy});
    chk({tag, ".busy"},       {31'd0, busy4}, {31'd0, bs});
  endtask

  typedef struct {
    logic       lv;
    logic [3:0] data;
    logic       dir;
    logic       so;
    logic       bv;
    logic       dn;
    logic       rdy;
    logic       bs;
  } vec_t;

  vec_t vt[22];

  // Inputs are applied at the falling edge; outputs are register-decoded,
  // so the row's expectations describe the cycle that is already running.
  initial begin
    logic [3:0] q4w[$];
    logic       q4d[$];
    logic [7:0] q8w[$];
    logic       q8d[$];
    logic [3:0] rx4;
    logic [7:0] rx8;
    int         sent4, sent8, cyc;
    logic [3:0] exp_bits;

    //            lv   data  dir  so   bv   dn   rdy  bs
    // LSB first, 4'b1011 -> 1,1,0,1
    vt[0]  = '{1'b1, 4'hB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[1]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[2]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[3]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[4]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vt[5]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    // MSB first, 4'b1011, inputs disturbed mid-frame -> 1,0,1,1
    vt[6]  = '{1'b1, 4'hB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[7]  = '{1'b1, 4'h4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[8]  = '{1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[9]  = '{1'b0, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[10] = '{1'b0, 4'h7, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vt[11] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    // Back-to-back: 4'hA MSB first then 4'h5 LSB first -> 1,0,1,0,1,0,1,0
    vt[12] = '{1'b1, 4'hA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[13] = '{1'b1, 4'h5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[14] = '{1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[15] = '{1'b1, 4'h5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[16] = '{1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vt[17] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[18] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[19] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[20] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vt[21] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reset held with a word offered: outputs quiet, ready high, no transfer.
    rst = 1'b1;
    lv4 = 1'b1; data4 = 4'hF; dir4 = 1'b0;
    lv8 = 1'b0; data8 = 8'h00; dir8 = 1'b0;
    @(negedge clk);
    chk4("rst_hold0", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk4("rst_hold1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    lv4 = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk4("post_rst", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 22; i++) begin
      lv4 = vt[i].lv; data4 = vt[i].data; dir4 = vt[i].dir;
      #1;
      chk4($sformatf("vec%0d", i), vt[i].so, vt[i].bv, vt[i].dn, vt[i].rdy, vt[i].bs);
      @(negedge clk);
    end

    // Reset mid-frame: 4'hF, abort after two bits.
    lv4 = 1'b1; data4 = 4'hF; dir4 = 1'b0;
    @(negedge clk);
    lv4 = 1'b0;
    chk4("abort_b0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk4("abort_b1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk4("abort_async", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk4("abort_hold", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk4("abort_rel", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    // Fresh frame after release: 4'h3 LSB first -> 1,1,0,0
    lv4 = 1'b1; data4 = 4'h3; dir4 = 1'b0;
    @(negedge clk);
    lv4 = 1'b0;
    exp_bits = 4'b0011;
    for (int b = 0; b < 4; b++) begin
      chk4($sformatf("fresh_b%0d", b), exp_bits[b], 1'b1, (b == 3), (b == 3), 1'b1);
      @(negedge clk);
    end
    chk4("fresh_idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Random loopback on both widths with a receiver model per instance.
    sent4 = 0; sent8 = 0; rx4 = '0; rx8 = '0; cyc = 0;
    while (cyc < 20000 && !(sent4 >= 200 && sent8 >= 200 &&
                            q4w.size() == 0 && q8w.size() == 0)) begin
      if (bv4) begin
        if (q4w.size() == 0) chk("lb4_spurious_bit", 32'd1, 32'd0);
        else rx4 = q4d[0] ? {rx4[2:0], so4} : {so4, rx4[3:1]};
      end
      if (done4) begin
        if (q4w.size() == 0) chk("lb4_spurious_done", 32'd1, 32'd0);
        else begin
          chk("lb4_word", {28'd0, rx4}, {28'd0, q4w[0]});
          void'(q4w.pop_front()); void'(q4d.pop_front());
        end
      end
      if (bv8) begin
        if (q8w.size() == 0) chk("lb8_spurious_bit", 32'd1, 32'd0);
        else rx8 = q8d[0] ? {rx8[6:0], so8} : {so8, rx8[7:1]};
      end
      if (done8) begin
        if (q8w.size() == 0) chk("lb8_spurious_done", 32'd1, 32'd0);
        else begin
          chk("lb8_word", {24'd0, rx8}, {24'd0, q8w[0]});
          void'(q8w.pop_front()); void'(q8d.pop_front());
        end
      end

      lv4   = (sent4 < 200) && ($urandom_range(0, 3) != 0);
      data4 = 4'($urandom);
      dir4  = 1'($urandom);
      if (lv4 && rdy4) begin
        q4w.push_back(data4); q4d.push_back(dir4); sent4++;
      end
      lv8   = (sent8 < 200) && ($urandom_range(0, 3) != 0);
      data8 = 8'($urandom);
      dir8  = 1'($urandom);
      if (lv8 && rdy8) begin
        q8w.push_back(data8); q8d.push_back(dir8); sent8++;
      end
      @(negedge clk);
      cyc++;
    end
    lv4 = 1'b0; lv8 = 1'b0;
    chk("lb4_all_sent", sent4, 32'd200);
    chk("lb8_all_sent", sent8, 32'd200);
    chk("lb4_drained", q4w.size(), 32'd0);
    chk("lb8_drained", q8w.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
